// File: rtl/d_cache_write_buffer.sv
// Write-back line buffer between the d_cache AXI write master and memory.
// Flushes are acknowledged early, lines drain to memory in FIFO order, and refills are held off while their line is still buffered.
module d_cache_write_buffer #(
  parameter int         ADDR_WIDTH         = 26,
  parameter int         DATA_WIDTH         = 32,
  parameter int         BLOCK_OFFSET_WIDTH = 2,
  parameter int         DEPTH              = 2,
  parameter logic [3:0] WR_ID              = 4'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [3:0]            s_awlen,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic                  s_arvalid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arready,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [3:0]            m_awlen,
  output logic [3:0]            m_awid,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wlast,
  output logic [3:0]            m_wid,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic                  m_arvalid,
  input  logic                  m_arready
);

  localparam int LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH;
  localparam int TAG_LSB   = BLOCK_OFFSET_WIDTH + 2;
  localparam int TAG_W     = ADDR_WIDTH - TAG_LSB;
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int BEAT_W    = (BLOCK_OFFSET_WIDTH > 0) ? BLOCK_OFFSET_WIDTH : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_SIZE - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [3:0]        AWLEN_C   = 4'(LINE_SIZE);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_DATA = 2'd1,
    F_RESP = 2'd2
  } fill_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ADDR = 2'd1,
    D_DATA = 2'd2,
    D_RESP = 2'd3
  } drain_e;

  fill_e                  f_state_q, f_state_d;
  drain_e                 d_state_q, d_state_d;
  logic [PTR_W-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [BEAT_W-1:0]      fbeat_q, fbeat_d, dbeat_q, dbeat_d;
  logic [TAG_W-1:0]       fill_tag_q, fill_tag_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0]  data_q [DEPTH][LINE_SIZE];

  logic                   s_awready_q, s_wready_q, s_bvalid_q;
  logic                   m_awvalid_q, m_wvalid_q, m_wlast_q, m_bready_q;
  logic [ADDR_WIDTH-1:0]  m_awaddr_q;
  logic [DATA_WIDTH-1:0]  m_wdata_q;

  logic                   aw_fire_s, wr_beat_s, commit_s, pop_s, hit_s;
  logic [TAG_W-1:0]       ar_tag_s;
  logic                   unused_s;

  assign unused_s = ^{s_awlen, s_awaddr[TAG_LSB-1:0], s_araddr[TAG_LSB-1:0]};

  // Fill side: accept one flush burst at a time and commit it as a whole line
  always_comb begin
    f_state_d  = f_state_q;
    wp_d       = wp_q;
    fbeat_d    = fbeat_q;
    fill_tag_d = fill_tag_q;
    aw_fire_s  = 1'b0;
    wr_beat_s  = 1'b0;
    commit_s   = 1'b0;
    case (f_state_q)
      F_IDLE: begin
        if (s_awvalid && s_awready_q) begin
          aw_fire_s  = 1'b1;
          fill_tag_d = s_awaddr[ADDR_WIDTH-1:TAG_LSB];
          fbeat_d    = '0;
          f_state_d  = F_DATA;
        end else begin
          f_state_d = F_IDLE;
        end
      end
      F_DATA: begin
        if (s_wvalid && s_wready_q) begin
          wr_beat_s = 1'b1;
          fbeat_d   = fbeat_q + BEAT_W'(1);
          if (s_wlast || (fbeat_q == LAST_BEAT)) begin
            commit_s  = 1'b1;
            wp_d      = wp_q + PTR_W'(1);
            f_state_d = F_RESP;
          end else begin
            f_state_d = F_DATA;
          end
        end else begin
          f_state_d = F_DATA;
        end
      end
      F_RESP: begin
        if (s_bready) begin
          f_state_d = F_IDLE;
        end else begin
          f_state_d = F_RESP;
        end
      end
      default: f_state_d = F_IDLE;
    endcase
  end

  // Drain side: address, beats, then wait for the memory response before popping
  always_comb begin
    d_state_d = d_state_q;
    rp_d      = rp_q;
    dbeat_d   = dbeat_q;
    pop_s     = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        if (count_q != '0) begin
          d_state_d = D_ADDR;
        end else begin
          d_state_d = D_IDLE;
        end
      end
      D_ADDR: begin
        if (m_awready && m_awvalid_q) begin
          dbeat_d   = '0;
          d_state_d = D_DATA;
        end else begin
          d_state_d = D_ADDR;
        end
      end
      D_DATA: begin
        if (m_wready && m_wvalid_q) begin
          if (dbeat_q == LAST_BEAT) begin
            d_state_d = D_RESP;
          end else begin
            dbeat_d = dbeat_q + BEAT_W'(1);
          end
        end else begin
          d_state_d = D_DATA;
        end
      end
      D_RESP: begin
        if (m_bvalid) begin
          pop_s     = 1'b1;
          rp_d      = rp_q + PTR_W'(1);
          d_state_d = D_IDLE;
        end else begin
          d_state_d = D_RESP;
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  // Occupancy and per-entry valid bits; commit and pop never target the same entry
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (commit_s) begin
      valid_d[wp_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
    if (pop_s) begin
      valid_d[rp_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    case ({commit_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Read-after-write gate: a refill waits while its line is buffered or still being filled
  always_comb begin
    ar_tag_s = s_araddr[ADDR_WIDTH-1:TAG_LSB];
    hit_s    = (f_state_q != F_IDLE) && (fill_tag_q == ar_tag_s);
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (valid_q[i] && (tag_q[i] == ar_tag_s));
    end
    hit_s = hit_s & s_arvalid;
  end

  // State, pointers and registered outputs, all derived from next-state values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_state_q   <= F_IDLE;
      d_state_q   <= D_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      fbeat_q     <= '0;
      dbeat_q     <= '0;
      fill_tag_q  <= '0;
      valid_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
      s_awready_q <= 1'b1;
      s_wready_q  <= 1'b0;
      s_bvalid_q  <= 1'b0;
      m_awvalid_q <= 1'b0;
      m_awaddr_q  <= '0;
      m_wvalid_q  <= 1'b0;
      m_wdata_q   <= '0;
      m_wlast_q   <= 1'b0;
      m_bready_q  <= 1'b0;
    end else begin
      f_state_q   <= f_state_d;
      d_state_q   <= d_state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      fbeat_q     <= fbeat_d;
      dbeat_q     <= dbeat_d;
      fill_tag_q  <= fill_tag_d;
      valid_q     <= valid_d;
      if (aw_fire_s) begin
        tag_q[wp_q] <= fill_tag_d;
      end
      s_awready_q <= (f_state_d == F_IDLE) && (count_d < DEPTH_C);
      s_wready_q  <= (f_state_d == F_DATA);
      s_bvalid_q  <= (f_state_d == F_RESP);
      m_awvalid_q <= (d_state_d == D_ADDR);
      m_awaddr_q  <= (d_state_d == D_ADDR) ? {tag_q[rp_d], {TAG_LSB{1'b0}}} : '0;
      m_wvalid_q  <= (d_state_d == D_DATA);
      m_wdata_q   <= (d_state_d == D_DATA) ? data_q[rp_d][dbeat_d] : '0;
      m_wlast_q   <= (d_state_d == D_DATA) && (dbeat_d == LAST_BEAT);
      m_bready_q  <= (d_state_d == D_RESP);
    end
  end

  // Line data store; contents of free entries are don't-care
  always_ff @(posedge clk) begin
    if (wr_beat_s) begin
      data_q[wp_q][fbeat_q] <= s_wdata;
    end
  end

  assign s_awready = s_awready_q;
  assign s_wready  = s_wready_q;
  assign s_bvalid  = s_bvalid_q;
  assign m_awvalid = m_awvalid_q;
  assign m_awaddr  = m_awaddr_q;
  assign m_awlen   = m_awvalid_q ? AWLEN_C : 4'd0;
  assign m_awid    = m_awvalid_q ? WR_ID : 4'd0;
  assign m_wvalid  = m_wvalid_q;
  assign m_wdata   = m_wdata_q;
  assign m_wlast   = m_wlast_q;
  assign m_wid     = m_wvalid_q ? WR_ID : 4'd0;
  assign m_bready  = m_bready_q;
  assign m_arvalid = s_arvalid & ~hit_s;
  assign s_arready = m_arready & ~hit_s;

endmodule

// File: tb/tb_d_cache_write_buffer.sv
// Scoreboard bench for d_cache_write_buffer: expected memory-side beats are queued as flushes are driven.
`timescale 1ns/1ps
module tb_d_cache_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_awvalid, s_awready;
  logic [25:0] s_awaddr;
  logic [3:0]  s_awlen;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic        s_arvalid, s_arready;
  logic [25:0] s_araddr;
  logic        m_awvalid, m_awready;
  logic [25:0] m_awaddr;
  logic [3:0]  m_awlen, m_awid, m_wid;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic        m_wlast;
  logic        m_bvalid, m_bready;
  logic        m_arvalid, m_arready;

  logic        b_en;
  logic        done5;
  int          total = 0;
  int          bad = 0;
  int          b_seen = 0;
  int          b_exp = 0;
  logic [25:0] exp_aw_q[$];
  logic [32:0] exp_w_q[$];
  logic [32:0] e_w;

  always #5 clk = ~clk;

  d_cache_write_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awid(m_awid), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wlast(m_wlast), .m_wid(m_wid), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side monitor: every accepted address/beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_awvalid && m_awready) begin
        chk("aw_expected", exp_aw_q.size() != 0, 1);
        if (exp_aw_q.size() != 0) chk("m_awaddr", m_awaddr, exp_aw_q.pop_front());
        chk("m_awlen", m_awlen, 4);
        chk("m_awid", m_awid, 1);
      end
      if (m_wvalid && m_wready) begin
        chk("w_expected", exp_w_q.size() != 0, 1);
        if (exp_w_q.size() != 0) begin
          e_w = exp_w_q.pop_front();
          chk("m_wdata", m_wdata, e_w[31:0]);
          chk("m_wlast", m_wlast, e_w[32]);
        end
        chk("m_wid", m_wid, 1);
      end
      if (s_bvalid && s_bready) b_seen++;
    end
  end

  // Memory write-response model
  initial begin
    m_bvalid = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      m_bvalid = b_en & m_bready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic flush(input logic [25:0] addr, input logic [31:0] base, input bit sim_pop);
    int n;
    exp_aw_q.push_back(addr);
    for (int i = 0; i < 4; i++) exp_w_q.push_back({(i == 3), base + 32'(i)});
    s_awvalid = 1'b1;
    s_awaddr  = addr;
    n = 0;
    while (!s_awready && n < 300) begin tick(); n++; end
    chk("aw_accept_wait", n < 300, 1);
    tick();
    s_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_wvalid = 1'b1;
      s_wdata  = base + 32'(i);
      s_wlast  = (i == 3);
      if (i == 3 && sim_pop) b_en = 1'b1;
      n = 0;
      while (!s_wready && n < 50) begin tick(); n++; end
      tick();
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    chk("bvalid_after_last", s_bvalid, 1);
    if (sim_pop) chk("count_commit_and_pop", dut.count_q, 1);
    b_exp++;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_aw_q.size() != 0 || exp_w_q.size() != 0 || dut.count_q != 0) && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_done", n < 1000, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; s_awvalid = 1'b0; s_awaddr = '0; s_awlen = 4'd4;
    s_wvalid = 1'b0; s_wdata = '0; s_wlast = 1'b0; s_bready = 1'b1;
    s_arvalid = 1'b0; s_araddr = '0; m_awready = 1'b1; m_wready = 1'b1;
    m_arready = 1'b0; b_en = 1'b1; done5 = 1'b0;
    repeat (3) tick();
    chk("rst_s_awready", s_awready, 1);
    chk("rst_s_wready", s_wready, 0);
    chk("rst_s_bvalid", s_bvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_count", dut.count_q, 0);
    rst_n = 1'b1;
    tick();

    // single flush
    flush(26'h0001040, 32'hA0, 1'b0);
    wait_drain();
    chk("t1_count_zero", dut.count_q, 0);

    // fill to full with the memory address channel stalled
    m_awready = 1'b0;
    flush(26'h100, 32'hB0, 1'b0);
    flush(26'h200, 32'hC0, 1'b0);
    tick(); tick();
    chk("t2_count_full", dut.count_q, 2);
    chk("t2_awready_full", s_awready, 0);
    fork
      flush(26'h240, 32'hD0, 1'b0);
      begin
        repeat (8) tick();
        chk("t2_awready_held", s_awready, 0);
        chk("t2_count_held", dut.count_q, 2);
        m_awready = 1'b1;
      end
    join
    wait_drain();

    // hazard gate
    m_awready = 1'b0;
    flush(26'h300, 32'hE0, 1'b0);
    m_arready = 1'b1;
    s_arvalid = 1'b1;
    s_araddr  = 26'h308;
    #1;
    chk("t3_hit_arvalid", m_arvalid, 0);
    chk("t3_hit_arready", s_arready, 0);
    s_araddr = 26'h400;
    #1;
    chk("t3_miss_arvalid", m_arvalid, 1);
    chk("t3_miss_arready", s_arready, 1);
    s_araddr = 26'h308;
    tick(); tick();
    m_awready = 1'b1;
    n = 0;
    while (dut.count_q != 0 && n < 200) begin
      chk("t3_gate_hold", m_arvalid, 0);
      tick();
      n++;
    end
    chk("t3_gate_lift", m_arvalid, 1);
    chk("t3_arready_lift", s_arready, 1);
    s_arvalid = 1'b0;
    m_arready = 1'b0;
    wait_drain();

    // commit and pop in the same cycle
    b_en = 1'b0;
    flush(26'h500, 32'h50, 1'b0);
    n = 0;
    while (!m_bready && n < 100) begin tick(); n++; end
    chk("t4_drain_in_resp", m_bready, 1);
    flush(26'h600, 32'h60, 1'b1);
    wait_drain();

    // five flushes through a two-entry buffer with memory W back-pressure
    fork
      begin
        for (int i = 0; i < 5; i++) flush(26'h1000 + 26'(i * 16), 32'h5000_0000 + 32'(i * 16), 1'b0);
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          m_wready = 1'($urandom_range(0, 1));
          tick();
        end
        m_wready = 1'b1;
      end
    join
    wait_drain();
    chk("t5_b_count", b_seen, b_exp);

    // reset mid-burst with one undrained line
    m_awready = 1'b0;
    flush(26'h680, 32'h68, 1'b0);
    s_awvalid = 1'b1;
    s_awaddr  = 26'h700;
    n = 0;
    while (!s_awready && n < 100) begin tick(); n++; end
    tick();
    s_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_wvalid = 1'b1;
      s_wdata  = 32'h70 + 32'(i);
      tick();
    end
    s_wvalid = 1'b0;
    rst_n = 1'b0;
    exp_aw_q.delete();
    exp_w_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    m_awready = 1'b1;
    tick();
    chk("t6_count", dut.count_q, 0);
    chk("t6_awready", s_awready, 1);
    for (int i = 0; i < 20; i++) begin
      chk("t6_no_bvalid", s_bvalid, 0);
      chk("t6_no_awvalid", m_awvalid, 0);
      tick();
    end
    chk("final_b_count", b_seen, b_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_cache_write_buffer.md
Name: d_cache_write_buffer

Overview:
- Write-back buffer on the d_cache memory side, between the d_cache AXI write master and the memory write ports.
- Absorbs dirty-line flush bursts into a small line FIFO and acknowledges each flush early, so the d_cache can start its refill without waiting for memory.
- Drains buffered lines to memory in order.
- Gates the d_cache read-address channel so a refill never reads a line still held in the buffer (read-after-write hazard).

Parameters:
- ADDR_WIDTH, 26, byte-address width; equals `ADDR_WIDTH.
- DATA_WIDTH, 32, word width; equals `DATA_WIDTH.
- BLOCK_OFFSET_WIDTH, 2, log2 of words per line; LINE_SIZE = 1 << BLOCK_OFFSET_WIDTH, at most 8.
- DEPTH, 2, number of line entries; power of two, at least 2.
- WR_ID, 4'd1, AWID/WID driven on the memory side.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- s_awvalid  in  1  flush address valid, from d_cache
- s_awready  out  1  buffer can accept a flush
- s_awaddr  in  ADDR_WIDTH  line-aligned flush address
- s_awlen  in  4  beat count; always LINE_SIZE, value ignored
- s_wvalid  in  1  flush data valid
- s_wready  out  1  flush data accepted
- s_wdata  in  DATA_WIDTH  flush word
- s_wlast  in  1  last flush word
- s_bvalid  out  1  early write response to d_cache
- s_bready  in  1  d_cache response ready
- s_arvalid  in  1  refill address valid, from d_cache
- s_araddr  in  ADDR_WIDTH  refill address
- s_arready  out  1  refill address accepted
- m_awvalid  out  1  memory write address valid
- m_awready  in  1  memory accepts address
- m_awaddr  out  ADDR_WIDTH  drained line address
- m_awlen  out  4  LINE_SIZE
- m_awid  out  4  WR_ID
- m_wvalid  out  1  memory write data valid
- m_wready  in  1  memory accepts word
- m_wdata  out  DATA_WIDTH  drained word
- m_wlast  out  1  last drained word
- m_wid  out  4  WR_ID
- m_bvalid  in  1  memory write response
- m_bready  out  1  buffer ready for response
- m_arvalid  out  1  refill address to memory
- m_arready  in  1  memory accepts refill address

Behaviour:
- Storage:
  - DEPTH entries, each holding a line tag (s_awaddr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH+2]) and LINE_SIZE words.
  - Circular write pointer wp and read pointer rp, each log2(DEPTH) bits and wrapping; occupancy counter count, 0..DEPTH.
- Fill FSM:
  - F_IDLE: s_awready = (count < DEPTH). On s_awvalid & s_awready, latch the tag into entry wp, clear the beat counter, go to F_DATA.
  - F_DATA: s_wready = 1. Each s_wvalid stores s_wdata into word[beat] and increments beat. The commit condition is s_wlast or beat == LINE_SIZE-1.
  - On commit: mark entry wp valid, wp++, go to F_RESP.
  - F_RESP: s_bvalid = 1; hold until s_bready, then go to F_IDLE.
  - s_bvalid is registered: asserted the cycle after the last beat.
- Drain FSM:
  - D_IDLE: if count > 0, go to D_ADDR.
  - D_ADDR: m_awvalid = 1 and m_awaddr = {tag[rp], 0s}. On m_awready, go to D_DATA with beat = 0.
  - D_DATA: m_wvalid = 1, m_wdata = word[rp][beat], m_wlast = (beat == LINE_SIZE-1). beat advances on m_wready. The last accepted beat moves to D_RESP.
  - D_RESP: m_bready = 1. On m_bvalid, invalidate entry rp, rp++, go to D_IDLE.
  - m_bready = 0 in all other drain states.
- Count:
  - +1 on commit, -1 on pop.
  - Commit and pop in the same cycle leave count unchanged.
  - Full (count == DEPTH) deasserts s_awready only; a burst already in F_DATA is never stalled.
- Hazard gate (combinational):
  - hit = s_arvalid and the line tag of s_araddr equals the tag of any valid entry, or of the entry in F_DATA/F_RESP.
  - m_arvalid = s_arvalid & ~hit; s_arready = m_arready & ~hit.
  - The gate lifts the cycle after the matching entry pops.
- Ordering: lines drain strictly FIFO. The same tag may occupy two entries; both drain in order, and the gate holds until neither remains.
- Reset:
  - All outputs 0 except s_awready = 1.
  - count = 0, wp = rp = 0, all entries invalid, both FSMs idle.
  - Reset mid-burst discards the partial line and any undrained lines; no B responses are issued for them.

Test Plan:
- Single flush, memory ready every cycle:
  - Stimulus: AW 0x0001040, 4 words 0xA0..0xA3.
  - Response: s_bvalid the cycle after the 4th beat; m_awaddr 0x0001040; m_wdata 0xA0..0xA3 with m_wlast on the 4th beat; count back to 0 after m_bvalid.
- Fill to full:
  - Stimulus: m_awready held at 0; two flushes (0x100, 0x200) committed.
  - Response: count = 2, s_awready = 0; a third AW waits until the first m_bvalid pops 0x100.
- Hazard:
  - Stimulus: line 0x300 buffered, memory stalled; s_arvalid with s_araddr 0x308.
  - Response: m_arvalid = 0 and s_arready = 0 until 0x300 pops; s_araddr 0x400 passes in the same cycle.
- Simultaneous commit and pop:
  - Stimulus: last fill beat lands in the cycle m_bvalid arrives for the prior entry.
  - Response: count unchanged at 1; the new line drains next.
- Wrap:
  - Stimulus: 5 sequential flushes with DEPTH = 2.
  - Response: all 5 appear on the memory side in order with correct data; pointers wrap without loss.
- Reset mid-burst:
  - Stimulus: rst_n low after 2 of 4 beats.
  - Response: count 0, s_awready 1, no s_bvalid, no m_awvalid afterward.
